regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-read-port integer register file for the RV32E core.
//  Generations beyond the single-cycle core use it in place of the fixed 16x32 file.
//  - x0 is hard-wired to zero.
//  - Optional write-to-read bypass.
//  - Per-register busy scoreboard for pipelined hazard detection.
//  - Sticky error flag for accesses to registers RV32E does not implement (x16-x31).
// PARAMETERS
//  BIT_WIDTH  32  data width of each register
//  DEPTH      16  implemented registers; 16 = RV32E, 32 = RV32I
//  ADDR_W     5   register-address width; 5 keeps full RV encoding, so 16..31 are illegal when DEPTH=16
//  NUM_RD     2   number of independent read ports
//  BYPASS     1   1 = same-cycle write data forwarded to matching reads; 0 = reads return the pre-write value
// PORTS
//  clk          in   1                 rising-edge clock
//  rst          in   1                 asynchronous, active-high reset
//  we           in   1                 write enable (writeback)
//  waddr        in   ADDR_W            write address
//  wdata        in   BIT_WIDTH         write data
//  raddr        in   NUM_RD*ADDR_W     read addresses; port i = bits [i*ADDR_W +: ADDR_W]
//  rdata        out  NUM_RD*BIT_WIDTH  read data; port i = bits [i*BIT_WIDTH +: BIT_WIDTH]
//  sb_set       in   1                 mark sb_addr busy (issue of an instruction with rd)
//  sb_addr      in   ADDR_W            register being claimed
//  rbusy        out  NUM_RD            per-port: addressed register has a pending write
//  err          out  1                 sticky illegal-address flag
// BEHAVIOUR
//  Reset
//  - While rst=1 (asynchronous): all registers = 0, all busy bits = 0, err = 0.
//  - Consequently rdata = 0 and rbusy = 0 during reset.
//  - Any write, sb_set or error in the reset-release cycle is ignored only while rst is high.
//  Write
//  - At posedge clk, if we && waddr != 0 && waddr < DEPTH: reg[waddr] <= wdata. Write latency 1 cycle.
//  - Writes to x0 or to an address >= DEPTH are dropped.
//  Read
//  - Combinational, 0-cycle latency, all ports independent.
//  - raddr == 0 -> 0.
//  - raddr >= DEPTH -> 0.
//  - Otherwise -> reg[raddr].
//  - BYPASS=1 only: if we && waddr == raddr[i] && legal && non-zero, rdata[i] = wdata.
//  Scoreboard
//  - busy[r] set at posedge when sb_set && sb_addr == r, with r != 0 and r < DEPTH.
//  - busy[r] cleared at posedge when we && waddr == r.
//  - Set and clear on the same r in the same cycle: set wins (busy stays 1, newer producer).
//  - busy[0] is constantly 0.
//  - rbusy[i] = busy[raddr[i]], forced 0 for x0 or an illegal address.
//  - BYPASS=1 only: rbusy[i] = 0 when this cycle's write clears that register, unless sb_set also targets it.
//  Error
//  - err <= 1 at posedge on any of: we with waddr >= DEPTH; sb_set with sb_addr >= DEPTH;
//    any raddr[i] >= DEPTH (evaluated every cycle).
//  - err holds until rst; it is never cleared otherwise.
//  Widths
//  - Address comparisons are unsigned, at full ADDR_W.
//  - DEPTH must be <= 2**ADDR_W; elaboration fails otherwise.
//  - Storage is DEPTH-1 registers; x0 has no flop.
// STRUCTURE
//  Package regfile_pkg
//  - RV32E constants: XLEN=32, NREGS_E=16, REG_ADDR_W=5.
//  - typedefs reg_addr_t and xdata_t.
//  - ZERO_REG=0.
//  Sub-module regfile_scoreboard
//  - Busy vector with set/clear priority logic and rbusy lookup.
//  - Parametrised by DEPTH, ADDR_W, NUM_RD.
//  Top level
//  - Storage array (generate loop of per-register flops with async reset).
//  - Read muxes, bypass logic and error flag.
// TESTING
//  1. Reset: pulse rst mid-run after writing x5=32'hDEADBEEF -> during reset rdata and rbusy read 0;
//     x5 still reads 0 afterwards.
//  2. x0: we=1, waddr=0, wdata=32'hFFFF_FFFF -> raddr=0 reads 0 on every port, in the same cycle and
//     the next; err stays 0.
//  3. Bypass: we=1, waddr=7, wdata=32'h1234_5678 with raddr0=7 in the same cycle -> BYPASS=1 gives
//     32'h1234_5678 immediately; BYPASS=0 gives the old value, then 32'h1234_5678 next cycle.
//  4. Dual-port read: write x1=1 and x15=32'h8000_0000, then raddr0=1, raddr1=15 -> both values
//     are returned simultaneously.
//  5. Scoreboard: sb_set on x3 -> rbusy=1 next cycle. Write x3 -> busy clears. Simultaneous
//     sb_set(x3) and write(x3) -> busy stays 1.
//  6. Illegal address (DEPTH=16): we=1, waddr=20 -> no register changes; raddr=20 reads 0;
//     err=1 next cycle and stays 1 until rst.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants, types and address helpers for the multi-port register file.
//   XLEN, NREGS_E, REG_ADDR_W : RV32E defaults
//   reg_addr_t, xdata_t       : register address / data types
//   ZERO_REG                  : hard-wired zero register index
package regfile_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned NREGS_E    = 16;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ZERO_REG   = 0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xdata_t;

  // Address names an implemented register (callers zero-extend to 32 bits).
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

  // Address names an implemented register that has storage (excludes x0).
  function automatic logic addr_writable(input logic [31:0] addr, input int unsigned depth);
    return (addr != ZERO_REG) && (addr < depth);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for the register file.
//   clk, rst        : clock, asynchronous active-high reset
//   we, waddr       : writeback clears the busy bit of waddr
//   sb_set, sb_addr : issue marks sb_addr busy (wins over a same-cycle clear)
//   raddr           : NUM_RD packed read addresses
//   rbusy           : per-port busy status of the addressed register
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH  = NREGS_E,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD-1:0]        rbusy
);

  localparam int unsigned NumAddr = 1 << ADDR_W;

  // x0 has no busy flop; bit 0 of the extended view is constant zero.
  logic [DEPTH-1:1]   busy_d, busy_q;
  logic [NumAddr-1:0] busy_ext;

  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < int'(DEPTH); r++) begin
      if (we && waddr == ADDR_W'(r)) begin
        busy_d[r] = 1'b0;
      end
      // Applied after the clear so a newer producer keeps the register busy.
      if (sb_set && sb_addr == ADDR_W'(r)) begin
        busy_d[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Addresses at or above DEPTH look up a zero entry.
  always_comb begin
    busy_ext              = '0;
    busy_ext[DEPTH-1:1]   = busy_q;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_port
    logic [ADDR_W-1:0] ra;
    logic              fwd_clr;

    assign ra = raddr[i*ADDR_W +: ADDR_W];
    // A write retiring this cycle already resolves the hazard when bypass is on.
    assign fwd_clr = (BYPASS != 0) && we && (waddr == ra) && !(sb_set && (sb_addr == ra));
    assign rbusy[i] = busy_ext[ra] && !fwd_clr;
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port integer register file.
//   clk, rst        : clock, asynchronous active-high reset
//   we/waddr/wdata  : writeback port (x0 and addresses >= DEPTH dropped)
//   raddr/rdata     : NUM_RD combinational read ports, packed
//   sb_set/sb_addr  : scoreboard claim of a destination register
//   rbusy           : per-port pending-write status
//   err             : sticky flag for any access to an address >= DEPTH
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = XLEN,
  parameter int unsigned DEPTH     = NREGS_E,
  parameter int unsigned ADDR_W    = REG_ADDR_W,
  parameter int unsigned NUM_RD    = 2,
  parameter int unsigned BYPASS    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [ADDR_W-1:0]           waddr,
  input  logic [BIT_WIDTH-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0]    raddr,
  output logic [NUM_RD*BIT_WIDTH-1:0] rdata,
  input  logic                        sb_set,
  input  logic [ADDR_W-1:0]           sb_addr,
  output logic [NUM_RD-1:0]           rbusy,
  output logic                        err
);

  localparam int unsigned NumAddr = 1 << ADDR_W;

  if (DEPTH > NumAddr || DEPTH < 2) begin : g_bad_depth
    $error("regfile_mp: DEPTH must be in 2..2**ADDR_W");
  end

  logic waddr_ok;
  assign waddr_ok = addr_writable(32'(waddr), DEPTH);

  // Full address-space view: x0 and unimplemented entries read as zero.
  logic [BIT_WIDTH-1:0] rf [NumAddr];
  assign rf[0] = '0;

  for (genvar r = 1; r < NumAddr; r++) begin : g_reg
    if (r < DEPTH) begin : g_impl
      logic [BIT_WIDTH-1:0] reg_d, reg_q;

      always_comb begin
        reg_d = reg_q;
        if (we && waddr_ok && waddr == ADDR_W'(r)) begin
          reg_d = wdata;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          reg_q <= '0;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign rf[r] = reg_q;
    end else begin : g_unimpl
      assign rf[r] = '0;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              fwd;

    assign ra = raddr[i*ADDR_W +: ADDR_W];
    // Forwarding is held off during reset so rdata reads zero there.
    assign fwd = (BYPASS != 0) && !rst && we && waddr_ok && (waddr == ra);
    assign rdata[i*BIT_WIDTH +: BIT_WIDTH] = fwd ? wdata : rf[ra];
  end

  regfile_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .sb_set  (sb_set),
    .sb_addr (sb_addr),
    .raddr   (raddr),
    .rbusy   (rbusy)
  );

  logic err_d, err_q;

  always_comb begin
    err_d = err_q;
    if (we && !addr_in_range(32'(waddr), DEPTH)) begin
      err_d = 1'b1;
    end
    if (sb_set && !addr_in_range(32'(sb_addr), DEPTH)) begin
      err_d = 1'b1;
    end
    for (int i = 0; i < int'(NUM_RD); i++) begin
      if (!addr_in_range(32'(raddr[i*ADDR_W +: ADDR_W]), DEPTH)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned NR    = 2;
  localparam int          DEPTH = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           we;
  logic [AW-1:0]  waddr;
  logic [DW-1:0]  wdata;
  logic [AW-1:0]  ra [NR];
  logic [NR*AW-1:0] raddr;
  logic           sb_set;
  logic [AW-1:0]  sb_addr;
  logic [NR*DW-1:0] rdata_b, rdata_n;
  logic [NR-1:0]  rbusy_b, rbusy_n;
  logic           err_b, err_n;

  assign raddr = {ra[1], ra[0]};

  always #5 clk = ~clk;

  regfile_mp #(.BIT_WIDTH(DW), .DEPTH(DEPTH), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_b), .sb_set(sb_set), .sb_addr(sb_addr), .rbusy(rbusy_b), .err(err_b)
  );

  regfile_mp #(.BIT_WIDTH(DW), .DEPTH(DEPTH), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_n), .sb_set(sb_set), .sb_addr(sb_addr), .rbusy(rbusy_n), .err(err_n)
  );

  // Reference model: architectural register contents, pending-write set, sticky error.
  logic [31:0] m_reg  [32];
  bit          m_busy [32];
  bit          m_err;

  int checks = 0;
  int errors = 0;

  function automatic bit legal_nz(int a);
    return a != 0 && a < DEPTH;
  endfunction

  task automatic reset_model();
    for (int k = 0; k < 32; k++) begin
      m_reg[k]  = '0;
      m_busy[k] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  function automatic logic [31:0] exp_rd(int p, bit byp);
    int a = int'(ra[p]);
    if (rst || !legal_nz(a)) return '0;
    if (byp && we && int'(waddr) == a) return wdata;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(int p, bit byp);
    int a = int'(ra[p]);
    if (rst || !legal_nz(a)) return 1'b0;
    if (byp && we && int'(waddr) == a && !(sb_set && int'(sb_addr) == a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_update();
    if (rst) begin
      reset_model();
    end else begin
      if ((we && int'(waddr) >= DEPTH) || (sb_set && int'(sb_addr) >= DEPTH)) m_err = 1'b1;
      for (int p = 0; p < int'(NR); p++) if (int'(ra[p]) >= DEPTH) m_err = 1'b1;
      if (we && legal_nz(int'(waddr))) begin
        m_reg[waddr]  = wdata;
        m_busy[waddr] = 1'b0;
      end
      if (sb_set && legal_nz(int'(sb_addr))) m_busy[sb_addr] = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int p = 0; p < int'(NR); p++) begin
      chk($sformatf("%s_rd%0d_byp", tag, p), rdata_b[p*DW +: DW], exp_rd(p, 1'b1));
      chk($sformatf("%s_rd%0d_nobyp", tag, p), rdata_n[p*DW +: DW], exp_rd(p, 1'b0));
      chk($sformatf("%s_busy%0d_byp", tag, p), 32'(rbusy_b[p]), 32'(exp_busy(p, 1'b1)));
      chk($sformatf("%s_busy%0d_nobyp", tag, p), 32'(rbusy_n[p]), 32'(exp_busy(p, 1'b0)));
    end
    chk({tag, "_err_byp"}, 32'(err_b), 32'(m_err));
    chk({tag, "_err_nobyp"}, 32'(err_n), 32'(m_err));
  endtask

  // Check combinational outputs mid-cycle, then clock and advance the model.
  task automatic cycle(input string tag);
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    we = 1'b0; waddr = '0; wdata = '0; sb_set = 1'b0; sb_addr = '0;
    ra[0] = '0; ra[1] = '0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    we = 1'b1; waddr = AW'(a); wdata = d;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    reset_model();
    #1;
    check_all("init_rst");
    cycle("init_rst_clk");
    rst = 1'b0;

    // 1. mid-run reset wipes x5 and busy state
    idle(); wr(5, 32'hDEADBEEF); cycle("t1_wr");
    idle(); ra[0] = 5; sb_set = 1'b1; sb_addr = 5; cycle("t1_rd");
    idle(); ra[0] = 5; cycle("t1_busy");
    rst = 1'b1; wr(7, 32'hCAFE_F00D); ra[0] = 5; ra[1] = 7; sb_set = 1'b1; sb_addr = 7;
    #1;
    reset_model();
    check_all("t1_in_rst");
    cycle("t1_rst_clk");
    rst = 1'b0;
    idle(); ra[0] = 5; ra[1] = 7; cycle("t1_after");

    // 2. x0 stays zero
    idle(); wr(0, 32'hFFFF_FFFF); cycle("t2_wr_x0");
    idle(); cycle("t2_next");

    // 3. bypass vs. pre-write value
    idle(); wr(7, 32'hAAAA_5555); cycle("t3_init");
    idle(); wr(7, 32'h1234_5678); ra[0] = 7; cycle("t3_same");
    idle(); ra[0] = 7; cycle("t3_next");

    // 4. dual-port read
    idle(); wr(1, 32'h1); cycle("t4_w1");
    idle(); wr(15, 32'h8000_0000); cycle("t4_w15");
    idle(); ra[0] = 1; ra[1] = 15; cycle("t4_rd");

    // 5. scoreboard set / clear / set-wins
    idle(); sb_set = 1'b1; sb_addr = 3; cycle("t5_set");
    idle(); ra[0] = 3; cycle("t5_busy");
    idle(); wr(3, 32'h33); ra[0] = 3; cycle("t5_clr");
    idle(); ra[0] = 3; cycle("t5_cleared");
    idle(); sb_set = 1'b1; sb_addr = 3; cycle("t5_set2");
    idle(); sb_set = 1'b1; sb_addr = 3; wr(3, 32'h44); ra[0] = 3; ra[1] = 3; cycle("t5_both");
    idle(); ra[0] = 3; cycle("t5_still");

    // Random traffic on legal addresses only: err must stay low.
    for (int n = 0; n < 200; n++) begin
      idle();
      if ($urandom_range(0, 1) == 1) wr(int'($urandom_range(0, DEPTH - 1)), $urandom());
      sb_set  = ($urandom_range(0, 3) == 0);
      sb_addr = AW'($urandom_range(0, DEPTH - 1));
      ra[0]   = AW'($urandom_range(0, DEPTH - 1));
      ra[1]   = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, DEPTH - 1));
      cycle("rnd_legal");
    end

    // 6. illegal address
    idle(); wr(20, 32'hBAD0_BAD0); ra[0] = 20; ra[1] = 4; cycle("t6_wr20");
    idle(); ra[0] = 20; ra[1] = 1; cycle("t6_err");
    for (int n = 0; n < 3; n++) begin
      idle(); ra[0] = AW'(n + 1); cycle("t6_sticky");
    end

    // Random traffic over the whole address space.
    for (int n = 0; n < 200; n++) begin
      idle();
      if ($urandom_range(0, 1) == 1) wr(int'($urandom_range(0, 31)), $urandom());
      sb_set  = ($urandom_range(0, 2) == 0);
      sb_addr = AW'($urandom_range(0, 31));
      ra[0]   = AW'($urandom_range(0, 31));
      ra[1]   = ($urandom_range(0, 3) == 0) ? sb_addr : AW'($urandom_range(0, 31));
      cycle("rnd_full");
    end

    // Only reset clears err.
    idle(); rst = 1'b1;
    #1;
    reset_model();
    check_all("final_rst");
    cycle("final_rst_clk");
    rst = 1'b0;
    idle(); ra[0] = 3; ra[1] = 15; cycle("final_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
